irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_IRQ, default 16, number of interrupt channels (1..32).
REQ-002 Parameter EDGE_MASK, default 0 (N_IRQ bits), bit i = 1 makes channel i rising-edge triggered; 0 makes it level triggered.
REQ-003 Parameter RR_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 clock  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 int_req  input  N_IRQ  raw interrupt request lines.
REQ-007 mie  input  N_IRQ  per-channel enable.
REQ-008 glb_en  input  1  global interrupt enable (mstatus.MIE).
REQ-009 int_take  input  1  one-cycle pulse: core has entered the trap.
REQ-010 int_ret  input  1  one-cycle pulse: core executed mret.
REQ-011 INT_  output  1  interrupt request to core.
REQ-012 mcause  output  32  bit 31 = 1, bits 4:0 = serviced channel id, other bits 0.
REQ-013 int_fin  output  N_IRQ  one-hot, one-cycle completion pulse for the serviced channel.
REQ-014 busy  output  1  high in states REQ, SERVICE and FIN.

Function
REQ-015 Pending vector: a level channel is pending while int_req[i] = 1; an edge channel sets pending[i] on a 0->1 transition of registered int_req[i].
REQ-016 An edge channel's pending[i] clears in the FIN cycle for that channel; if a new rising edge arrives in the same cycle, the set wins.
REQ-017 Eligible vector = pending & mie, gated by glb_en.
REQ-018 Fixed mode: select the lowest-index eligible channel.
REQ-019 Round-robin mode: select the first eligible channel at index above the last serviced id, wrapping modulo N_IRQ; after reset the last id is N_IRQ-1.
REQ-020 FSM states: IDLE, REQ, SERVICE, FIN.
REQ-021 IDLE -> REQ when any channel is eligible; latch the selected id into mcause. INT_ is high from the next cycle (1-cycle latency).
REQ-022 REQ: INT_ = 1 and the id is frozen.
REQ-023 REQ -> SERVICE on int_take.
REQ-024 REQ -> IDLE, dropping INT_ the next cycle, if the latched channel stops being eligible before int_take (level drop, mie clear, glb_en clear); no int_fin is produced.
REQ-025 int_take and loss of eligibility in the same cycle: int_take wins.
REQ-026 SERVICE: INT_ = 0 and there is no nesting; new requests remain pending.
REQ-027 SERVICE -> FIN on int_ret.
REQ-028 FIN: lasts exactly one cycle, int_fin[id] = 1, the last serviced id is updated, then -> IDLE.
REQ-029 int_take outside REQ and int_ret outside SERVICE are ignored.
REQ-030 mcause holds its value from the IDLE->REQ transition until the next IDLE->REQ transition.
REQ-031 Channels at index N_IRQ or above do not exist; mcause[4:0] is always < N_IRQ.

Reset
REQ-032 While reset is high, on the clock edge: state = IDLE, pending = 0, registered int_req = 0, last id = N_IRQ-1, mcause = 0.
REQ-033 While reset is high, on the clock edge: INT_ = 0, int_fin = 0, busy = 0.
REQ-034 Reset asserted in any state, including mid-SERVICE, aborts the interrupt without an int_fin pulse.
REQ-035 Reset has priority over int_take and int_ret.

Structure
REQ-036 Package irq_ctrl_pkg holds the FSM state enum, the MCAUSE_IRQ_BIT constant (31) and the id width constant (5).
REQ-037 Channel selection is a sub-module irq_arbiter (eligible vector, last id, mode in; valid, id out), purely combinational.
REQ-038 All other logic stays in irq_controller, with a single clocked process plus combinational next-state logic.

Verification
REQ-039 Fixed mode, N_IRQ=16: level int_req bits 3 and 7 with mie all ones -> INT_ high the next cycle, mcause = 0x80000003.
REQ-040 Fixed mode, continuing: int_take then int_ret -> int_fin = 0x0008 for one cycle, then channel 7 is served.
REQ-041 Round-robin mode: channels 2 and 5 held high through three services -> service order 2, 5, 2.
REQ-042 Edge channel 4 pulsed for 1 cycle, mie[4] = 1 -> pending is kept, and after int_ret int_fin = 0x0010 and pending[4] clears.
REQ-043 Edge channel 4 with a new rising edge in its FIN cycle -> pending is re-set and channel 4 is serviced again.
REQ-044 In REQ, mie cleared before int_take -> INT_ drops one cycle later and no int_fin is produced.
REQ-045 Reset asserted in SERVICE -> next cycle state IDLE, INT_ = 0, mcause = 0, no int_fin pulse.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller slice.
//   MCAUSE_IRQ_BIT : bit of mcause flagging an interrupt (vs. exception)
//   ID_W           : width of a channel id (up to 32 channels)
//   irq_state_e    : controller FSM states
package irq_ctrl_pkg;

  localparam int MCAUSE_IRQ_BIT = 31;
  localparam int ID_W           = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE,
    ST_FIN
  } irq_state_e;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational channel selector.
//   eligible : channels currently allowed to interrupt
//   last_id  : id of the most recently serviced channel (round-robin anchor)
//   rr_mode  : 0 = lowest index wins, 1 = first eligible above last_id, wrapping
//   valid    : at least one channel is eligible
//   id       : selected channel (only meaningful when valid)
module irq_arbiter
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic [N_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]  last_id,
  input  logic             rr_mode,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  logic [ID_W-1:0] lo_id;
  logic [ID_W-1:0] hi_id;
  logic            hi_valid;

  // Scanning downwards leaves the lowest matching index in each candidate.
  // lo_* is the lowest eligible channel overall; hi_* is the lowest one
  // strictly above last_id. Round-robin prefers hi_* and wraps to lo_*.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    hi_valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_id = ID_W'(i);
        if (ID_W'(i) > last_id) begin
          hi_id    = ID_W'(i);
          hi_valid = 1'b1;
        end
      end
    end
  end

  assign valid = |eligible;
  assign id    = (rr_mode && hi_valid) ? hi_id : lo_id;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: collects level/edge requests, arbitrates one channel,
// raises INT_ to the core and tracks the trap through take/mret handshakes.
//   clock, reset : system clock, synchronous active-high reset
//   int_req      : raw request lines        mie      : per-channel enable
//   glb_en       : global interrupt enable  int_take : core entered the trap
//   int_ret      : core executed mret       INT_     : request to the core
//   mcause       : {1, 0..., id}            int_fin  : one-hot completion pulse
//   busy         : high while in REQ, SERVICE or FIN
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int               N_IRQ     = 16,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
  parameter int               RR_MODE   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] int_req,
  input  logic [N_IRQ-1:0] mie,
  input  logic             glb_en,
  input  logic             int_take,
  input  logic             int_ret,
  output logic             INT_,
  output logic [31:0]      mcause,
  output logic [N_IRQ-1:0] int_fin,
  output logic             busy
);

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] req_q, req_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [31:0]      mcause_q, mcause_d;
  logic             int_q, int_d;
  logic [N_IRQ-1:0] fin_q, fin_d;
  logic             busy_q, busy_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] cur_onehot;
  logic [N_IRQ-1:0] fin_clr;
  logic [ID_W-1:0]  cur_id;
  logic             cur_eligible;
  logic             arb_valid;
  logic [ID_W-1:0]  arb_id;

  // The serviced id lives in mcause, which only changes on IDLE->REQ.
  assign cur_id = mcause_q[ID_W-1:0];

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) begin
      cur_onehot[i] = (cur_id == ID_W'(i));
    end
  end

  // Edge channels take their pending bit from the sticky register,
  // level channels follow the raw line directly.
  assign rise         = int_req & ~req_q;
  assign pending      = (int_req & ~EDGE_MASK) | (pend_q & EDGE_MASK);
  assign eligible     = glb_en ? (pending & mie) : '0;
  assign cur_eligible = |(eligible & cur_onehot);
  assign fin_clr      = (state_q == ST_FIN) ? cur_onehot : '0;

  irq_arbiter #(
    .N_IRQ (N_IRQ)
  ) u_arbiter (
    .eligible (eligible),
    .last_id  (last_id_q),
    .rr_mode  (RR_MODE != 0),
    .valid    (arb_valid),
    .id       (arb_id)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = int_req;
    // A rising edge in the FIN cycle beats the clear of the same channel.
    pend_d    = ((pend_q & ~fin_clr) | rise) & EDGE_MASK;
    last_id_d = last_id_q;
    mcause_d  = mcause_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d                  = ST_REQ;
          mcause_d                 = '0;
          mcause_d[MCAUSE_IRQ_BIT] = 1'b1;
          mcause_d[ID_W-1:0]       = arb_id;
        end
      end
      ST_REQ: begin
        // int_take wins over a simultaneous loss of eligibility.
        if (int_take)           state_d = ST_SERVICE;
        else if (!cur_eligible) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (int_ret) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        last_id_d = cur_id;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    int_d  = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
    fin_d  = (state_d == ST_FIN) ? cur_onehot : '0;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values of the previous cycle regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pend_q    <= '0;
      last_id_q <= ID_W'(N_IRQ - 1);
      mcause_q  <= '0;
      int_q     <= 1'b0;
      fin_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pend_q    <= pend_d;
      last_id_q <= last_id_d;
      mcause_q  <= mcause_d;
      int_q     <= int_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
    end
  end

  assign INT_    = int_q;
  assign mcause  = mcause_q;
  assign int_fin = fin_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: a fixed-priority instance (channel 4 edge-triggered)
// and a round-robin instance share one stimulus bus. Completion pulses are
// checked against per-instance scoreboard queues filled when int_ret is driven.
module tb_irq_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] int_req;
  logic [15:0] mie;
  logic        glb_en;
  logic        int_take;
  logic        int_ret;

  logic        fx_int,    rr_int;
  logic [31:0] fx_mcause, rr_mcause;
  logic [15:0] fx_fin,    rr_fin;
  logic        fx_busy,   rr_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_fx[$];
  logic [15:0] exp_rr[$];
  bit          mon_fx = 1'b0;
  bit          mon_rr = 1'b0;

  always #5 clock = ~clock;

  irq_controller #(
    .N_IRQ     (16),
    .EDGE_MASK (16'h0010),
    .RR_MODE   (0)
  ) dut_fx (
    .clock    (clock),
    .reset    (reset),
    .int_req  (int_req),
    .mie      (mie),
    .glb_en   (glb_en),
    .int_take (int_take),
    .int_ret  (int_ret),
    .INT_     (fx_int),
    .mcause   (fx_mcause),
    .int_fin  (fx_fin),
    .busy     (fx_busy)
  );

  irq_controller #(
    .N_IRQ     (16),
    .EDGE_MASK (16'h0000),
    .RR_MODE   (1)
  ) dut_rr (
    .clock    (clock),
    .reset    (reset),
    .int_req  (int_req),
    .mie      (mie),
    .glb_en   (glb_en),
    .int_take (int_take),
    .int_ret  (int_ret),
    .INT_     (rr_int),
    .mcause   (rr_mcause),
    .int_fin  (rr_fin),
    .busy     (rr_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Completion pulses: every nonzero int_fin must match the head of the queue.
  always @(negedge clock) begin
    if (mon_fx && fx_fin != 16'h0) begin
      if (exp_fx.size() == 0) check("fx_fin_unexpected", {16'h0, fx_fin}, 32'h0);
      else                    check("fx_fin", {16'h0, fx_fin}, {16'h0, exp_fx.pop_front()});
    end
    if (mon_rr && rr_fin != 16'h0) begin
      if (exp_rr.size() == 0) check("rr_fin_unexpected", {16'h0, rr_fin}, 32'h0);
      else                    check("rr_fin", {16'h0, rr_fin}, {16'h0, exp_rr.pop_front()});
    end
  end

  task automatic do_reset();
    mon_fx   = 1'b0;
    mon_rr   = 1'b0;
    reset    = 1'b1;
    int_req  = '0;
    mie      = '0;
    glb_en   = 1'b0;
    int_take = 1'b0;
    int_ret  = 1'b0;
    tick();
    check("rst_fx_int",    {31'h0, fx_int},  32'h0);
    check("rst_fx_mcause", fx_mcause,        32'h0);
    check("rst_fx_busy",   {31'h0, fx_busy}, 32'h0);
    check("rst_rr_fin",    {16'h0, rr_fin},  32'h0);
    reset = 1'b0;
  endtask

  // Starting in REQ: take the trap, return, expect one completion pulse.
  // ret_req is driven during the int_ret cycle, fin_req during the FIN cycle.
  task automatic serve(input bit sel, input logic [15:0] exp_fin,
                       input logic [15:0] ret_req, input logic [15:0] fin_req);
    int_take = 1'b1;
    tick();
    int_take = 1'b0;
    check("svc_int_low", {31'h0, sel ? rr_int : fx_int},  32'h0);
    check("svc_busy",    {31'h0, sel ? rr_busy : fx_busy}, 32'h1);
    tick();
    int_req = ret_req;
    int_ret = 1'b1;
    if (sel) exp_rr.push_back(exp_fin);
    else     exp_fx.push_back(exp_fin);
    tick();
    int_ret = 1'b0;
    int_req = fin_req;
    check("fin_busy", {31'h0, sel ? rr_busy : fx_busy}, 32'h1);
    tick();
    check("post_fin_busy", {31'h0, sel ? rr_busy : fx_busy}, 32'h0);
  endtask

  initial begin
    // Fixed priority, levels 3 and 7.
    do_reset();
    mon_fx   = 1'b1;
    mie      = 16'hFFFF;
    glb_en   = 1'b1;
    int_take = 1'b1;
    int_ret  = 1'b1;
    tick();
    int_take = 1'b0;
    int_ret  = 1'b0;
    check("idle_ignores_take", {31'h0, fx_busy}, 32'h0);
    int_req = 16'h0088;
    tick();
    check("fx_int_1", {31'h0, fx_int}, 32'h1);
    check("fx_mcause_3", fx_mcause, 32'h8000_0003);
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    check("req_ignores_ret", {31'h0, fx_int}, 32'h1);
    serve(1'b0, 16'h0008, 16'h0080, 16'h0080);
    check("mcause_held", fx_mcause, 32'h8000_0003);
    tick();
    check("fx_mcause_7", fx_mcause, 32'h8000_0007);
    serve(1'b0, 16'h0080, 16'h0000, 16'h0000);

    // Round-robin, levels 2 and 5 held: order 2, 5, 2.
    do_reset();
    mon_rr  = 1'b1;
    mie     = 16'hFFFF;
    glb_en  = 1'b1;
    int_req = 16'h0024;
    tick();
    check("rr_mcause_2a", rr_mcause, 32'h8000_0002);
    serve(1'b1, 16'h0004, 16'h0024, 16'h0024);
    tick();
    check("rr_mcause_5", rr_mcause, 32'h8000_0005);
    serve(1'b1, 16'h0020, 16'h0024, 16'h0024);
    tick();
    check("rr_mcause_2b", rr_mcause, 32'h8000_0002);
    serve(1'b1, 16'h0004, 16'h0000, 16'h0000);

    // Edge channel 4: one-cycle pulse stays pending until FIN.
    do_reset();
    mon_fx  = 1'b1;
    mie     = 16'hFFFF;
    glb_en  = 1'b1;
    int_req = 16'h0010;
    tick();
    int_req = 16'h0000;
    tick();
    check("edge_int", {31'h0, fx_int}, 32'h1);
    check("edge_mcause", fx_mcause, 32'h8000_0004);
    tick();
    check("edge_kept", {31'h0, fx_int}, 32'h1);
    serve(1'b0, 16'h0010, 16'h0000, 16'h0000);
    tick();
    check("edge_cleared", {31'h0, fx_busy}, 32'h0);

    // New rising edge during FIN re-arms channel 4.
    int_req = 16'h0010;
    tick();
    int_req = 16'h0000;
    tick();
    check("rearm_req", {31'h0, fx_int}, 32'h1);
    serve(1'b0, 16'h0010, 16'h0000, 16'h0010);
    int_req = 16'h0000;
    tick();
    check("rearm_int", {31'h0, fx_int}, 32'h1);
    check("rearm_mcause", fx_mcause, 32'h8000_0004);
    serve(1'b0, 16'h0010, 16'h0000, 16'h0000);
    tick();
    check("rearm_done", {31'h0, fx_int}, 32'h0);

    // mie cleared in REQ drops INT_ without completion.
    int_req = 16'h0200;
    tick();
    check("mie_req", fx_mcause, 32'h8000_0009);
    mie = 16'h0000;
    tick();
    check("mie_drop_int",  {31'h0, fx_int},  32'h0);
    check("mie_drop_busy", {31'h0, fx_busy}, 32'h0);
    // int_take together with loss of eligibility: take wins.
    mie = 16'hFFFF;
    tick();
    check("take_wins_req", {31'h0, fx_int}, 32'h1);
    mie      = 16'h0000;
    int_take = 1'b1;
    tick();
    int_take = 1'b0;
    check("take_wins_busy", {31'h0, fx_busy}, 32'h1);
    int_req = 16'h0000;
    int_ret = 1'b1;
    exp_fx.push_back(16'h0200);
    tick();
    int_ret = 1'b0;
    tick();
    // glb_en low masks everything.
    glb_en  = 1'b0;
    mie     = 16'hFFFF;
    int_req = 16'h0200;
    tick();
    tick();
    check("glb_masked", {31'h0, fx_busy}, 32'h0);

    // Reset during SERVICE aborts without int_fin, even with int_ret present.
    glb_en  = 1'b1;
    int_req = 16'h0040;
    tick();
    int_take = 1'b1;
    tick();
    int_take = 1'b0;
    check("pre_rst_busy", {31'h0, fx_busy}, 32'h1);
    reset   = 1'b1;
    int_ret = 1'b1;
    tick();
    check("svc_rst_int",    {31'h0, fx_int},  32'h0);
    check("svc_rst_mcause", fx_mcause,        32'h0);
    check("svc_rst_busy",   {31'h0, fx_busy}, 32'h0);
    check("svc_rst_fin",    {16'h0, fx_fin},  32'h0);
    reset   = 1'b0;
    int_ret = 1'b0;
    int_req = 16'h0000;
    tick();
    tick();
    check("post_rst_idle", {31'h0, fx_busy}, 32'h0);

    check("fx_queue_empty", exp_fx.size(), 32'h0);
    check("rr_queue_empty", exp_rr.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
